// File: rtl/management_arbiter.sv
// Two-port arbiter sharing the core management port between the JTAG debug
// controller and the host bus bridge, with a stall timeout on the core side.
module management_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jtag_request,
  input  logic        jtag_writeEnable,
  input  logic [3:0]  jtag_byteSelect,
  input  logic [19:0] jtag_address,
  input  logic [31:0] jtag_writeData,
  output logic [31:0] jtag_readData,
  output logic        jtag_ack,
  output logic        jtag_error,
  input  logic        host_request,
  input  logic        host_writeEnable,
  input  logic [3:0]  host_byteSelect,
  input  logic [19:0] host_address,
  input  logic [31:0] host_writeData,
  output logic [31:0] host_readData,
  output logic        host_ack,
  output logic        host_error,
  output logic        core_enable,
  output logic        core_writeEnable,
  output logic [3:0]  core_byteSelect,
  output logic [19:0] core_address,
  output logic [31:0] core_writeData,
  input  logic [31:0] core_readData,
  input  logic        core_ready,
  output logic [1:0]  probe_grant
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} stateT;

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

  stateT       state, stateNext;
  logic        owner, ownerNext;
  logic        lastGrant, lastGrantNext;
  logic [15:0] count, countNext;
  logic        latchWe, latchWeNext;
  logic [3:0]  latchBs, latchBsNext;
  logic [19:0] latchAddr, latchAddrNext;
  logic [31:0] latchWd, latchWdNext;
  logic [31:0] capData, capDataNext;
  logic        capError, capErrorNext;
  logic        grantHost;
  logic        issueActive;
  logic        respondActive;

  // Owner and lastGrant encode the port as 0 = jtag, 1 = host.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      lastGrant <= 1'b1;
      count     <= '0;
      latchWe   <= 1'b0;
      latchBs   <= '0;
      latchAddr <= '0;
      latchWd   <= '0;
      capData   <= '0;
      capError  <= 1'b0;
    end else begin
      state     <= stateNext;
      owner     <= ownerNext;
      lastGrant <= lastGrantNext;
      count     <= countNext;
      latchWe   <= latchWeNext;
      latchBs   <= latchBsNext;
      latchAddr <= latchAddrNext;
      latchWd   <= latchWdNext;
      capData   <= capDataNext;
      capError  <= capErrorNext;
    end
  end

  always_comb begin
    grantHost = host_request;
    if (jtag_request && host_request) begin
      grantHost = (FIXED_PRIORITY != 0) ? 1'b0 : !lastGrant;
    end
  end

  always_comb begin
    stateNext     = state;
    ownerNext     = owner;
    lastGrantNext = lastGrant;
    countNext     = count;
    latchWeNext   = latchWe;
    latchBsNext   = latchBs;
    latchAddrNext = latchAddr;
    latchWdNext   = latchWd;
    capDataNext   = capData;
    capErrorNext  = capError;
    case (state)
      IDLE: begin
        if (jtag_request || host_request) begin
          ownerNext     = grantHost;
          countNext     = '0;
          latchWeNext   = grantHost ? host_writeEnable : jtag_writeEnable;
          latchBsNext   = grantHost ? host_byteSelect  : jtag_byteSelect;
          latchAddrNext = grantHost ? host_address     : jtag_address;
          latchWdNext   = grantHost ? host_writeData   : jtag_writeData;
          stateNext     = ISSUE;
        end
      end
      // Ready has priority over the terminal count so a late completion still succeeds.
      ISSUE: begin
        if (core_ready) begin
          capDataNext  = latchWe ? 32'h0 : core_readData;
          capErrorNext = 1'b0;
          stateNext    = RESPOND;
        end else if (count == LAST_COUNT) begin
          capDataNext  = 32'hFFFF_FFFF;
          capErrorNext = 1'b1;
          stateNext    = RESPOND;
        end else begin
          countNext = count + 16'd1;
        end
      end
      RESPOND: begin
        lastGrantNext = owner;
        stateNext     = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outputs decode from registered state only, so reset clears them without a clock.
  always_comb begin
    issueActive      = (state == ISSUE);
    respondActive    = (state == RESPOND);
    core_enable      = issueActive;
    core_writeEnable = issueActive && latchWe;
    core_byteSelect  = issueActive ? latchBs : 4'h0;
    core_address     = issueActive ? latchAddr : 20'h0;
    core_writeData   = (issueActive && latchWe) ? latchWd : 32'h0;
    probe_grant      = 2'b00;
    if (issueActive || respondActive) begin
      probe_grant = owner ? 2'b10 : 2'b01;
    end
    jtag_ack      = respondActive && !owner;
    host_ack      = respondActive && owner;
    jtag_readData = jtag_ack ? capData : 32'h0;
    host_readData = host_ack ? capData : 32'h0;
    jtag_error    = jtag_ack && capError;
    host_error    = host_ack && capError;
  end

endmodule

// File: tb/tb_management_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter share stimulus;
// per-instance queues hold expected transactions checked by a negedge monitor.
module tb_management_arbiter;

  typedef struct {
    logic        port;
    logic        we;
    logic [3:0]  bs;
    logic [19:0] addr;
    logic [31:0] wd;
    logic [31:0] data;
    logic        err;
    int          enCycles;
  } expectT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jtagRequest = 1'b0, jtagWriteEnable = 1'b0;
  logic [3:0]  jtagByteSelect = '0;
  logic [19:0] jtagAddress = '0;
  logic [31:0] jtagWriteData = '0;
  logic        hostRequest = 1'b0, hostWriteEnable = 1'b0;
  logic [3:0]  hostByteSelect = '0;
  logic [19:0] hostAddress = '0;
  logic [31:0] hostWriteData = '0;
  logic [31:0] coreReadData = '0;
  logic        coreReady = 1'b0;

  logic [31:0] jtagReadData0, hostReadData0, coreWriteData0;
  logic        jtagAck0, jtagError0, hostAck0, hostError0, coreEnable0, coreWriteEnable0;
  logic [3:0]  coreByteSelect0;
  logic [19:0] coreAddress0;
  logic [1:0]  probeGrant0;
  logic [31:0] jtagReadData1, hostReadData1, coreWriteData1;
  logic        jtagAck1, jtagError1, hostAck1, hostError1, coreEnable1, coreWriteEnable1;
  logic [3:0]  coreByteSelect1;
  logic [19:0] coreAddress1;
  logic [1:0]  probeGrant1;

  expectT sb0[$];
  expectT sb1[$];
  int     compared = 0;
  int     mismatched = 0;
  int     enCyc[2] = '{0, 0};
  int     ackCount[2] = '{0, 0};

  always #5 clk = ~clk;

  management_arbiter #(.TIMEOUT_CYCLES(4), .FIXED_PRIORITY(0)) dutRr (
    .clk(clk), .rst_n(rst_n),
    .jtag_request(jtagRequest), .jtag_writeEnable(jtagWriteEnable),
    .jtag_byteSelect(jtagByteSelect), .jtag_address(jtagAddress),
    .jtag_writeData(jtagWriteData), .jtag_readData(jtagReadData0),
    .jtag_ack(jtagAck0), .jtag_error(jtagError0),
    .host_request(hostRequest), .host_writeEnable(hostWriteEnable),
    .host_byteSelect(hostByteSelect), .host_address(hostAddress),
    .host_writeData(hostWriteData), .host_readData(hostReadData0),
    .host_ack(hostAck0), .host_error(hostError0),
    .core_enable(coreEnable0), .core_writeEnable(coreWriteEnable0),
    .core_byteSelect(coreByteSelect0), .core_address(coreAddress0),
    .core_writeData(coreWriteData0), .core_readData(coreReadData),
    .core_ready(coreReady), .probe_grant(probeGrant0)
  );

  management_arbiter #(.TIMEOUT_CYCLES(4), .FIXED_PRIORITY(1)) dutFixed (
    .clk(clk), .rst_n(rst_n),
    .jtag_request(jtagRequest), .jtag_writeEnable(jtagWriteEnable),
    .jtag_byteSelect(jtagByteSelect), .jtag_address(jtagAddress),
    .jtag_writeData(jtagWriteData), .jtag_readData(jtagReadData1),
    .jtag_ack(jtagAck1), .jtag_error(jtagError1),
    .host_request(hostRequest), .host_writeEnable(hostWriteEnable),
    .host_byteSelect(hostByteSelect), .host_address(hostAddress),
    .host_writeData(hostWriteData), .host_readData(hostReadData1),
    .host_ack(hostAck1), .host_error(hostError1),
    .core_enable(coreEnable1), .core_writeEnable(coreWriteEnable1),
    .core_byteSelect(coreByteSelect1), .core_address(coreAddress1),
    .core_writeData(coreWriteData1), .core_readData(coreReadData),
    .core_ready(coreReady), .probe_grant(probeGrant1)
  );

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s dut%0d: got %h, expected %h", name, idx, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input int idx);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s dut%0d: event with no expected transaction", name, idx);
  endtask

  task automatic observeDut(input int idx, input logic en, input logic we,
                            input logic [3:0] bs, input logic [19:0] addr,
                            input logic [31:0] wd, input logic [1:0] grant,
                            input logic jAck, input logic jErr, input logic [31:0] jData,
                            input logic hAck, input logic hErr, input logic [31:0] hData);
    expectT e;
    logic   haveFront;
    haveFront = (idx == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
    if (haveFront) e = (idx == 0) ? sb0[0] : sb1[0];
    if (en) begin
      enCyc[idx]++;
      if (!haveFront) reportFail("unexpected_enable", idx);
      else begin
        checkOutput("probe_grant", idx, 32'(grant), e.port ? 32'd2 : 32'd1);
        checkOutput("core_address", idx, 32'(addr), 32'(e.addr));
        checkOutput("core_writeEnable", idx, 32'(we), 32'(e.we));
        checkOutput("core_byteSelect", idx, 32'(bs), 32'(e.bs));
        checkOutput("core_writeData", idx, wd, e.we ? e.wd : 32'h0);
      end
    end
    if (jAck || hAck) begin
      ackCount[idx]++;
      checkOutput("ack_overlap", idx, 32'(jAck && hAck), 32'd0);
      checkOutput("ack_with_enable", idx, 32'(en), 32'd0);
      if (!haveFront) reportFail("unexpected_ack", idx);
      else begin
        if (idx == 0) void'(sb0.pop_front());
        else void'(sb1.pop_front());
        checkOutput("ack_port", idx, 32'(hAck), 32'(e.port));
        checkOutput("readData", idx, hAck ? hData : jData, e.data);
        checkOutput("error", idx, 32'(hAck ? hErr : jErr), 32'(e.err));
        checkOutput("other_port_quiet", idx, hAck ? (jData | 32'(jErr)) : (hData | 32'(hErr)), 32'h0);
        checkOutput("enable_cycles", idx, 32'(enCyc[idx]), 32'(e.enCycles));
      end
      enCyc[idx] = 0;
    end
  endtask

  // Monitor: samples both arbiters on the falling edge, away from state changes.
  always @(negedge clk) begin
    if (rst_n) begin
      observeDut(0, coreEnable0, coreWriteEnable0, coreByteSelect0, coreAddress0,
                 coreWriteData0, probeGrant0, jtagAck0, jtagError0, jtagReadData0,
                 hostAck0, hostError0, hostReadData0);
      observeDut(1, coreEnable1, coreWriteEnable1, coreByteSelect1, coreAddress1,
                 coreWriteData1, probeGrant1, jtagAck1, jtagError1, jtagReadData1,
                 hostAck1, hostError1, hostReadData1);
    end
  end

  task automatic pushBoth(input expectT e0, input expectT e1);
    sb0.push_back(e0);
    sb1.push_back(e1);
  endtask

  // One single-requester transaction; stall < 0 means core_ready never rises.
  task automatic applyStimulus(input logic port, input logic we, input logic [3:0] bs,
                               input logic [19:0] addr, input logic [31:0] wd,
                               input int stall, input logic [31:0] rdata,
                               input logic [19:0] addrLate, input logic [31:0] expData,
                               input logic expErr, input int expEnCycles);
    expectT e;
    int     cyc;
    logic   done;
    e.port = port; e.we = we; e.bs = bs; e.addr = addr; e.wd = wd;
    e.data = expData; e.err = expErr; e.enCycles = expEnCycles;
    pushBoth(e, e);
    if (port) begin
      hostWriteEnable = we; hostByteSelect = bs; hostAddress = addr;
      hostWriteData = wd; hostRequest = 1'b1;
    end else begin
      jtagWriteEnable = we; jtagByteSelect = bs; jtagAddress = addr;
      jtagWriteData = wd; jtagRequest = 1'b1;
    end
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) begin
        if (port) hostAddress = addrLate;
        else jtagAddress = addrLate;
      end
      if (stall >= 0 && cyc == stall + 1) begin
        coreReady = 1'b1;
        coreReadData = rdata;
      end
      @(negedge clk);
      if (port ? hostAck0 : jtagAck0) done = 1'b1;
    end
    checkOutput("ack_seen", 0, 32'(done), 32'd1);
    checkOutput("latency", 0, 32'(cyc), 32'(expEnCycles + 1));
    @(posedge clk);
    #1;
    jtagRequest = 1'b0;
    hostRequest = 1'b0;
    coreReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    expectT ej, eh;
    int     base;

    // Outputs quiet while reset is held, before any clock edge.
    #2;
    checkOutput("reset_core_enable", 0, 32'(coreEnable0), 32'd0);
    checkOutput("reset_probe_grant", 0, 32'(probeGrant0), 32'd0);
    checkOutput("reset_acks", 0, 32'({jtagAck0, hostAck0}), 32'd0);
    checkOutput("reset_core_enable", 1, 32'(coreEnable1), 32'd0);
    checkOutput("reset_readData", 0, jtagReadData0 | hostReadData0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single jtag read");
    applyStimulus(1'b0, 1'b0, 4'hF, 20'h00010, 32'h0, 0, 32'hDEAD_BEEF,
                  20'h00010, 32'hDEAD_BEEF, 1'b0, 1);

    $display("[TB] host write with three stall cycles");
    applyStimulus(1'b1, 1'b1, 4'h3, 20'hFFFFF, 32'h1234_5678, 3, 32'h55AA_55AA,
                  20'hFFFFF, 32'h0, 1'b0, 4);

    $display("[TB] timeout with core_ready held low");
    applyStimulus(1'b0, 1'b0, 4'hF, 20'h00ABC, 32'h0, -1, 32'h0,
                  20'h00ABC, 32'hFFFF_FFFF, 1'b1, 4);

    $display("[TB] core_ready on terminal count");
    applyStimulus(1'b1, 1'b0, 4'hC, 20'h01234, 32'h0, 3, 32'h0BAD_F00D,
                  20'h01234, 32'h0BAD_F00D, 1'b0, 4);

    $display("[TB] both requesting continuously");
    ej.port = 1'b0; ej.we = 1'b0; ej.bs = 4'hF; ej.addr = 20'h11111; ej.wd = 32'h0;
    ej.data = 32'h0000_CAFE; ej.err = 1'b0; ej.enCycles = 1;
    eh = ej;
    eh.port = 1'b1; eh.bs = 4'h5; eh.addr = 20'h22222;
    pushBoth(ej, ej);
    pushBoth(eh, ej);
    pushBoth(ej, ej);
    pushBoth(eh, ej);
    jtagWriteEnable = 1'b0; jtagByteSelect = 4'hF; jtagAddress = 20'h11111;
    hostWriteEnable = 1'b0; hostByteSelect = 4'h5; hostAddress = 20'h22222;
    coreReady = 1'b1;
    coreReadData = 32'h0000_CAFE;
    jtagRequest = 1'b1;
    hostRequest = 1'b1;
    base = ackCount[0];
    for (int i = 0; i < 60 && ackCount[0] < base + 4; i++) @(posedge clk);
    #1;
    jtagRequest = 1'b0;
    hostRequest = 1'b0;
    coreReady = 1'b0;
    checkOutput("alternation_acks", 0, 32'(ackCount[0] - base), 32'd4);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] address change during issue");
    applyStimulus(1'b0, 1'b1, 4'hF, 20'h00100, 32'hA5A5_0100, 2, 32'h0,
                  20'h00200, 32'h0, 1'b0, 3);

    $display("[TB] asynchronous reset mid-issue");
    ej.port = 1'b0; ej.we = 1'b0; ej.bs = 4'hF; ej.addr = 20'h00300; ej.wd = 32'h0;
    ej.data = 32'h0; ej.err = 1'b0; ej.enCycles = 1;
    pushBoth(ej, ej);
    jtagWriteEnable = 1'b0; jtagByteSelect = 4'hF; jtagAddress = 20'h00300;
    jtagRequest = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_core_enable", 0, 32'(coreEnable0), 32'd0);
    checkOutput("async_probe_grant", 0, 32'(probeGrant0), 32'd0);
    checkOutput("async_core_address", 0, 32'(coreAddress0), 32'd0);
    checkOutput("async_acks", 0, 32'({jtagAck0, hostAck0}), 32'd0);
    checkOutput("async_core_enable", 1, 32'(coreEnable1), 32'd0);
    checkOutput("async_probe_grant", 1, 32'(probeGrant1), 32'd0);
    sb0.delete();
    sb1.delete();
    enCyc[0] = 0;
    enCyc[1] = 0;
    jtagRequest = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] first tie after reset");
    ej.addr = 20'h00ABC; ej.data = 32'h7777_0000;
    pushBoth(ej, ej);
    jtagAddress = 20'h00ABC;
    hostAddress = 20'h00DEF;
    hostByteSelect = 4'hF;
    coreReady = 1'b1;
    coreReadData = 32'h7777_0000;
    jtagRequest = 1'b1;
    hostRequest = 1'b1;
    base = ackCount[0];
    for (int i = 0; i < 20 && ackCount[0] < base + 1; i++) @(posedge clk);
    #1;
    jtagRequest = 1'b0;
    hostRequest = 1'b0;
    coreReady = 1'b0;
    checkOutput("tie_acks", 0, 32'(ackCount[0] - base), 32'd1);
    repeat (3) @(posedge clk);
    #1;

    checkOutput("scoreboard_drained", 0, 32'(sb0.size()), 32'd0);
    checkOutput("scoreboard_drained", 1, 32'(sb1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
